// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STALL_W   = 32;

  // Canonical NOP (addi x0, x0, 0) that the bubble consumers load.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_load_use_det.sv
// Load-use hazard comparator between the load in EX and the operands in ID.
module load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  output logic                 load_use_c
);

  // x0 is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    load_use_c = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule : load_use_det

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush/bubble strobes, MDU hold FSM, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = $clog2(MDU_LAT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_mdu_op,
  input  logic                 branch_taken,
  input  logic                 dmem_wait,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_bubble,
  output logic                 mdu_done,
  output logic [STALL_W-1:0]   stall_cycles
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STALL_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic                 load_use_c;

  load_use_det u_load_use_det (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use_c  (load_use_c)
  );

  // State, busy counter and stall counter registers (synchronous reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Next-state and strobe decode in priority order: reset, freeze, MDU hold, load-use, branch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_flush      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_done      = 1'b0;

    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_flush      = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
    end else if (dmem_wait) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (((state_q == RUN) && ex_mdu_op) ||
                 ((state_q == BUSY) && (cnt_q != '0))) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
      if (state_q == RUN) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(MDU_LAT - 2);
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end else begin
      // Release cycle of an MDU op falls through to normal RUN hazard rules.
      if (state_q == BUSY) begin
        mdu_done = 1'b1;
        state_d  = RUN;
      end
      if (load_use_c) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (branch_taken) begin
        if_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MDU_LAT = 4).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_mdu_op, branch_taken, dmem_wait;
  logic        pc_write, if_id_write, if_flush, id_ex_write;
  logic        id_ex_bubble, ex_mem_bubble, mdu_done;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_stall = 32'd0;

  pipe_ctrl #(.MDU_LAT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_mdu_op     (ex_mdu_op),
    .branch_taken  (branch_taken),
    .dmem_wait     (dmem_wait),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_flush      (if_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_bubble (ex_mem_bubble),
    .mdu_done      (mdu_done),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_mdu_op = 1'b0;
    branch_taken = 1'b0; dmem_wait = 1'b0;
  endtask

  // Packed strobes: {pc_write, if_id_write, id_ex_write, if_flush, id_ex_bubble, ex_mem_bubble, mdu_done}
  function automatic logic [6:0] strobes();
    return {pc_write, if_id_write, id_ex_write, if_flush, id_ex_bubble, ex_mem_bubble, mdu_done};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      checks++;
      if (strobes() !== 7'b000_1110) begin
        errors++;
        $display("FAIL reset_strobes cycle %0d: got %b want %b", i, strobes(), 7'b000_1110);
      end
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0h want 0", stall_cycles);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b111_0000) begin
      errors++;
      $display("FAIL run_defaults: got %b want %b", strobes(), 7'b111_0000);
    end
    exp_stall = 32'd0;
  endtask

  task automatic test_load_use();
    next_cycle();
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b001_0100) begin
      errors++;
      $display("FAIL load_use_rs2: got %b want %b", strobes(), 7'b001_0100);
    end
    exp_stall++;
    // Following cycle the load is in MEM.
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (strobes() !== 7'b111_0000) begin
      errors++;
      $display("FAIL load_use_resume: got %b want %b", strobes(), 7'b111_0000);
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
    // Load to x0 never stalls.
    next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b111_0000) begin
      errors++;
      $display("FAIL load_use_x0: got %b want %b", strobes(), 7'b111_0000);
    end
    // rs1 match counts, but only when the operand is actually used.
    next_cycle();
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_rs1_unused: got pc_write=%b want 1", pc_write);
    end
    id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b001_0100) begin
      errors++;
      $display("FAIL load_use_rs1: got %b want %b", strobes(), 7'b001_0100);
    end
    exp_stall++;
  endtask

  task automatic test_branch();
    next_cycle();
    clear_inputs();
    branch_taken = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b111_1000) begin
      errors++;
      $display("FAIL branch_flush: got %b want %b", strobes(), 7'b111_1000);
    end
    next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (strobes() !== 7'b001_0100) begin
      errors++;
      $display("FAIL branch_vs_load_use: got %b want %b", strobes(), 7'b001_0100);
    end
    exp_stall++;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL branch_stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_mdu();
    ex_mdu_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      branch_taken = (i == 1);
      #1;
      checks++;
      if (strobes() !== 7'b000_0010) begin
        errors++;
        $display("FAIL mdu_hold cycle %0d: got %b want %b", i, strobes(), 7'b000_0010);
      end
      next_cycle();
    end
    branch_taken = 1'b0;
    #1;
    checks++;
    if (strobes() !== 7'b111_0001) begin
      errors++;
      $display("FAIL mdu_release: got %b want %b", strobes(), 7'b111_0001);
    end
    exp_stall += 32'd3;
    next_cycle();
    ex_mdu_op = 1'b0;
    #1;
    checks++;
    if (strobes() !== 7'b111_0000) begin
      errors++;
      $display("FAIL mdu_after: got %b want %b", strobes(), 7'b111_0000);
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL mdu_stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_mdu_wait();
    // Per cycle: dmem_wait and expected strobes; cycles 2-3 are the freeze.
    logic        wait_v [6];
    logic [6:0]  exp_v  [6];
    wait_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v  = '{7'b000_0010, 7'b000_0010, 7'b000_0000, 7'b000_0000,
               7'b000_0010, 7'b111_0001};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      ex_mdu_op = 1'b1;
      dmem_wait = wait_v[i];
      branch_taken = wait_v[i];
      #1;
      checks++;
      if (strobes() !== exp_v[i]) begin
        errors++;
        $display("FAIL mdu_wait cycle %0d: got %b want %b", i, strobes(), exp_v[i]);
      end
    end
    exp_stall += 32'd5;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL mdu_wait_stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset_mid_busy();
    next_cycle();
    ex_mdu_op = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    ex_mdu_op = 1'b0;
    #1;
    checks++;
    if (strobes() !== 7'b111_0000) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b want %b", strobes(), 7'b111_0000);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_busy_cnt: got %0d want 0", stall_cycles);
    end
    exp_stall = 32'd0;
  endtask

  task automatic test_saturation();
    logic [31:0] exp_sat [3];
    exp_sat = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    next_cycle();
    clear_inputs();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      checks++;
      if (stall_cycles !== exp_sat[i]) begin
        errors++;
        $display("FAIL saturate cycle %0d: got %0h want %0h", i, stall_cycles, exp_sat[i]);
      end
    end
    dmem_wait = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_mdu_wait();
    test_reset_mid_busy();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core. It generates the write-enable, flush and bubble strobes for PC, IF/ID, ID/EX and EX/MEM. It resolves load-use hazards, taken-branch flushes from ID, multi-cycle MDU operations in EX, and data-memory wait freezes. It also keeps a saturating stall-cycle performance counter.

## Interface
- MDU_LAT, 4, total cycles an MDU op occupies EX (legal ≥ 2)
- CNT_W, $clog2(MDU_LAT), width of busy counter
- clk  in  1  clock; all state updates on posedge clk
- rst_n  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_mdu_op  in  1  EX instruction is a multi-cycle MDU op
- branch_taken  in  1  branch/jump resolved taken in ID
- dmem_wait  in  1  data memory not ready; freeze the pipeline
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID hold enable (1 = load)
- if_flush  out  1  IF/ID flush (zeroes pc/inst)
- id_ex_write  out  1  ID/EX load enable
- id_ex_bubble  out  1  ID/EX loads a NOP
- ex_mem_bubble  out  1  EX/MEM loads a NOP
- mdu_done  out  1  one-cycle pulse when the MDU op leaves EX
- stall_cycles  out  32  saturating count of cycles with pc_write = 0

## Operation
- State machine states: RUN and BUSY. The busy counter cnt is CNT_W bits wide.
- Default strobes in RUN: pc_write = if_id_write = id_ex_write = 1; if_flush = id_ex_bubble = ex_mem_bubble = mdu_done = 0.
- load_use = ex_mem_read & (ex_rd ≠ 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority order, highest first:
  1. Reset (rst_n = 0): pc_write = if_id_write = id_ex_write = 0; if_flush = id_ex_bubble = ex_mem_bubble = 1; state ← RUN, cnt ← 0, stall_cycles ← 0.
  2. dmem_wait = 1: freeze. pc_write, if_id_write and id_ex_write are 0; all flush/bubble strobes are 0. State and cnt hold; ex_mdu_op, load_use and branch_taken are ignored.
  3. MDU hold, in either of two cases:
     - RUN with ex_mdu_op = 1: state ← BUSY, cnt ← MDU_LAT−2.
     - BUSY with cnt ≠ 0: cnt ← cnt−1.
     - Strobes during hold: pc_write, if_id_write and id_ex_write are 0; ex_mem_bubble = 1; branch_taken is ignored.
  4. BUSY with cnt = 0 (release): mdu_done = 1, state ← RUN. This cycle otherwise follows RUN rules 5–6, except that ex_mdu_op does not re-trigger.
  5. load_use: pc_write = 0, if_id_write = 0, id_ex_bubble = 1. branch_taken is ignored because the ID operands are stale.
  6. branch_taken: if_flush = 1. PC, ID/EX and EX/MEM advance normally.
- stall_cycles increments on every non-reset cycle with pc_write = 0 and saturates at 32'hFFFF_FFFF.

## Timing
- All strobes are combinational from state, cnt and the inputs. No output register.
- An MDU op holds for exactly MDU_LAT−1 cycles and advances on cycle MDU_LAT. mdu_done is asserted on that cycle.
- A load-use stall lasts 1 cycle; the next cycle sees the load in MEM, so load_use = 0.
- Branch flush costs 1 cycle (one squashed fetch).
- dmem_wait inside BUSY pauses cnt, extending the hold by the number of wait cycles.
- Deasserting rst_n mid-BUSY returns to RUN on the next edge; the MDU op is discarded with the flushed pipeline.
- stall_cycles is registered and reflects cycles up to the previous edge.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, BUSY);
  - a NOP encoding constant, 32'h0000_0013, for the bubble consumers;
  - the register-index width constant, 5.
- Sub-module load_use_det: combinational comparator producing load_use.
- pipe_ctrl contains the FSM, the counter, the strobe decode and the performance counter.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles. Expect pc_write = 0, if_flush = 1, id_ex_bubble = 1, ex_mem_bubble = 1, stall_cycles = 0. After release, RUN defaults.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1. Expect 1 cycle of pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Repeat with ex_rd = 0; expect no stall.
- Branch: branch_taken = 1 with no hazard gives if_flush = 1, pc_write = 1. With branch_taken and load_use both high, expect a stall and no flush.
- MDU at MDU_LAT = 4: ex_mdu_op held high. Expect 3 hold cycles with ex_mem_bubble = 1, then an advance cycle with mdu_done = 1, and stall_cycles += 3.
- MDU plus wait: dmem_wait = 1 for 2 cycles during BUSY. Expect 5 hold cycles in total, cnt frozen during the wait, and no bubbles while frozen.
- Saturation: force stall_cycles near 32'hFFFF_FFFE and stall 3 cycles. Expect the count to stick at 32'hFFFF_FFFF.
